// File: rtl/mesh_term_endpoint.sv
// mesh_term_endpoint: synthesizable terminal device for one mesh router port.
// TX FIFO feeds the router via pndng/popin; RX FSM pops router packets into an RX FIFO.
module mesh_term_fifo #(
  parameter int W = 40,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic do_pop, do_push;
  assign not_empty = cnt != '0;
  assign full = cnt == (AW+1)'(D);
  assign do_pop = pop && not_empty;
  // A push on a full FIFO is accepted only when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign dout = not_empty ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

module mesh_term_endpoint #(
  parameter int pckg_sz = 40,
  parameter int fifo_depth = 4,
  parameter int ROW_ID = 0,
  parameter int COL_ID = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [pckg_sz-1:0] tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [pckg_sz-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_pndng,
  input  logic               rx_pop,
  output logic               misroute,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic [CNT_W-1:0]   rx_cnt
);
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
  state_t state, nxt;
  logic rx_full;
  logic tx_take;
  assign tx_take = popin && pndng_i_in;

  mesh_term_fifo #(.W(pckg_sz), .D(fifo_depth)) u_tx (
    .clk(clk), .reset(reset), .din(tx_data), .push(tx_push), .pop(popin),
    .dout(data_out_i_in), .not_empty(pndng_i_in), .full(tx_full)
  );

  mesh_term_fifo #(.W(pckg_sz), .D(fifo_depth)) u_rx (
    .clk(clk), .reset(reset), .din(data_out), .push(pop), .pop(rx_pop),
    .dout(rx_data), .not_empty(rx_pndng), .full(rx_full)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  // SETTLE gives the router a cycle to update pndng after each pop
  always_comb begin
    nxt = state;
    pop = 1'b0;
    nxt = state == IDLE ? ((pndng && !rx_full) ? POP : IDLE) :
          state == POP  ? SETTLE : IDLE;
    pop = state == POP;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      misroute <= 1'b0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      misroute <= pop && (data_out[pckg_sz-9 -: 4] != 4'(ROW_ID) ||
                          data_out[pckg_sz-13 -: 4] != 4'(COL_ID));
      if (tx_take && ~&tx_cnt) tx_cnt <= tx_cnt + CNT_W'(1);
      if (pop && ~&rx_cnt) rx_cnt <= rx_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mesh_term_endpoint.sv
// tb_mesh_term_endpoint: randomized bench against a queue-based model of the endpoint.
// Counters are narrowed so saturation is reached within the run.
module tb_mesh_term_endpoint;
  localparam int PW = 40, D = 4, ROW = 0, COL = 1, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b1;
  logic [PW-1:0] tx_data = '0, data_out = '0;
  logic tx_push = 1'b0, popin = 1'b0, pndng = 1'b0, rx_pop = 1'b0;
  logic tx_full, pndng_i_in, pop, rx_pndng, misroute;
  logic [PW-1:0] data_out_i_in, rx_data;
  logic [CW-1:0] tx_cnt, rx_cnt;
  int errs = 0, checks = 0;
  logic [PW-1:0] txq[$], rxq[$];
  int m_tx_cnt, m_rx_cnt, since;
  bit e_pop, e_mis;

  mesh_term_endpoint #(.pckg_sz(PW), .fifo_depth(D), .ROW_ID(ROW), .COL_ID(COL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .data_out(data_out), .pndng(pndng), .pop(pop), .rx_data(rx_data), .rx_pndng(rx_pndng),
    .rx_pop(rx_pop), .misroute(misroute), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] pkt(input bit good);
    logic [3:0] r;
    r = good ? 4'(ROW) : 4'(ROW + 1);
    return {8'($urandom), r, 4'(COL), 24'($urandom)};
  endfunction

  function automatic logic [PW-1:0] tx_head();
    return txq.size() != 0 ? txq[0] : '0;
  endfunction

  function automatic logic [PW-1:0] rx_head();
    return rxq.size() != 0 ? rxq[0] : '0;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_tx_cnt = 0;
    m_rx_cnt = 0;
    since = 2;
    e_pop = 0;
    e_mis = 0;
  endtask

  // One clock: apply the rules to the current inputs, then advance to 1ns after the edge
  task automatic step();
    bit tpop, tpush, rdeq, renq, np;
    tpop = popin && txq.size() != 0;
    tpush = tx_push && (txq.size() < D || tpop);
    rdeq = rx_pop && rxq.size() != 0;
    renq = e_pop;
    np = since >= 2 && pndng && rxq.size() < D;
    e_mis = renq && (data_out[PW-9 -: 4] != 4'(ROW) || data_out[PW-13 -: 4] != 4'(COL));
    if (tpop) begin
      void'(txq.pop_front());
      if (m_tx_cnt < CMAX) m_tx_cnt++;
    end
    if (tpush) txq.push_back(tx_data);
    if (rdeq) void'(rxq.pop_front());
    if (renq) begin
      rxq.push_back(data_out);
      if (m_rx_cnt < CMAX) m_rx_cnt++;
    end
    e_pop = np;
    since = np ? 0 : (since < 2 ? since + 1 : 2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit seen;
    model_reset();
    #12;
    checks++;
    if ({pop, pndng_i_in, data_out_i_in, rx_pndng, rx_data, tx_full, misroute, tx_cnt, rx_cnt} !== '0) begin
      errs++;
      $display("FAIL reset_hold outputs pop=%b pndng_i_in=%b dout=%h rx_pndng=%b rx_data=%h exp all 0", pop, pndng_i_in, data_out_i_in, rx_pndng, rx_data);
    end
    @(negedge clk);
    reset = 0;
    step();
    checks++;
    if ({pop, pndng_i_in, data_out_i_in, rx_pndng, rx_data, tx_full, misroute, tx_cnt, rx_cnt} !== '0) begin
      errs++;
      $display("FAIL reset_release outputs pop=%b pndng_i_in=%b dout=%h exp all 0", pop, pndng_i_in, data_out_i_in);
    end
    tx_push = 1;
    for (int i = 0; i < 3; i++) begin
      tx_data = pkt(1);
      step();
    end
    tx_push = 0;
    pndng = 1;
    data_out = pkt(1);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      seen = pop === 1'b1;
    end
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL reset_setup pop never rose, got %b exp 1", pop);
    end
    #3 reset = 1;
    #1;
    checks++;
    if ({pop, pndng_i_in, data_out_i_in, rx_pndng, rx_data, tx_full, misroute, tx_cnt, rx_cnt} !== '0) begin
      errs++;
      $display("FAIL reset_midxfer pop=%b pndng_i_in=%b dout=%h tx_cnt=%0d exp all 0", pop, pndng_i_in, data_out_i_in, tx_cnt);
    end
    pndng = 0;
    @(posedge clk);
    #2 reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pndng_i_in !== 1'b0 || pop !== 1'b0) begin
        errs++;
        $display("FAIL reset_after pndng_i_in=%b pop=%b exp 0 0", pndng_i_in, pop);
      end
    end
    tx_push = 1;
    tx_data = pkt(1);
    step();
    tx_push = 0;
    checks++;
    if (pndng_i_in !== 1'b1 || data_out_i_in !== tx_head()) begin
      errs++;
      $display("FAIL reset_first_push pndng_i_in=%b dout=%h exp 1 %h", pndng_i_in, data_out_i_in, tx_head());
    end
    popin = 1;
    step();
    popin = 0;
  endtask

  task automatic test_tx_drain();
    logic [PW-1:0] p[3];
    p[0] = 40'hAA12000001;
    p[1] = 40'hBB12000002;
    p[2] = 40'hCC12000003;
    for (int i = 0; i < 3; i++) begin
      tx_push = 1;
      tx_data = p[i];
      step();
    end
    tx_push = 0;
    for (int i = 0; i < 6; i++) begin
      popin = i % 2 == 0;
      if (popin) begin
        checks++;
        if (data_out_i_in !== p[i/2] || pndng_i_in !== 1'b1) begin
          errs++;
          $display("FAIL tx_drain_head[%0d] got %h/%b exp %h/1", i/2, data_out_i_in, pndng_i_in, p[i/2]);
        end
      end
      step();
      popin = 0;
      checks++;
      if (pndng_i_in !== (i < 4) || data_out_i_in !== tx_head()) begin
        errs++;
        $display("FAIL tx_drain_after[%0d] pndng_i_in=%b dout=%h exp %b %h", i, pndng_i_in, data_out_i_in, i < 4, tx_head());
      end
    end
    checks++;
    if (tx_cnt !== CW'(m_tx_cnt)) begin
      errs++;
      $display("FAIL tx_drain_cnt got %0d exp %0d", tx_cnt, m_tx_cnt);
    end
  endtask

  task automatic test_tx_full();
    logic [PW-1:0] p[5];
    for (int i = 0; i < 5; i++) begin
      tx_push = 1;
      tx_data = pkt(1);
      p[i] = tx_data;
      step();
      checks++;
      if (tx_full !== (i >= 3)) begin
        errs++;
        $display("FAIL tx_full[%0d] got %b exp %b", i, tx_full, i >= 3);
      end
    end
    tx_push = 0;
    for (int i = 0; i < 4; i++) begin
      popin = 1;
      checks++;
      if (data_out_i_in !== p[i]) begin
        errs++;
        $display("FAIL tx_full_order[%0d] got %h exp %h", i, data_out_i_in, p[i]);
      end
      step();
    end
    popin = 0;
    checks++;
    if (pndng_i_in !== 1'b0 || tx_full !== 1'b0) begin
      errs++;
      $display("FAIL tx_full_dropped pndng_i_in=%b tx_full=%b exp 0 0", pndng_i_in, tx_full);
    end
    tx_push = 1;
    for (int i = 0; i < 4; i++) begin
      tx_data = pkt(1);
      step();
    end
    popin = 1;
    tx_data = pkt(1);
    step();
    tx_push = 0;
    checks++;
    if (tx_full !== 1'b1 || data_out_i_in !== tx_head()) begin
      errs++;
      $display("FAIL tx_full_pushpop tx_full=%b dout=%h exp 1 %h", tx_full, data_out_i_in, tx_head());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out_i_in !== tx_head()) begin
        errs++;
        $display("FAIL tx_full_drain[%0d] got %h exp %h", i, data_out_i_in, tx_head());
      end
      step();
    end
    popin = 0;
  endtask

  task automatic test_rx_handshake();
    int npops;
    pndng = 0;
    rx_pop = 1;
    for (int i = 0; i < 6; i++) step();
    pndng = 1;
    npops = 0;
    for (int i = 0; i < 15; i++) begin
      data_out = pkt(1);
      step();
      npops += int'(pop === 1'b1);
      checks++;
      if (pop !== e_pop || rx_cnt !== CW'(m_rx_cnt) || misroute !== 1'b0 || rx_data !== rx_head()) begin
        errs++;
        $display("FAIL rx_handshake[%0d] pop=%b cnt=%0d mis=%b rx=%h exp %b %0d 0 %h", i, pop, rx_cnt, misroute, rx_data, e_pop, m_rx_cnt, rx_head());
      end
    end
    checks++;
    if (npops != 5) begin
      errs++;
      $display("FAIL rx_handshake_rate got %0d pops exp 5", npops);
    end
  endtask

  task automatic test_rx_backpressure();
    int first;
    rx_pop = 0;
    pndng = 1;
    for (int i = 0; i < 20; i++) begin
      data_out = pkt(1);
      step();
      checks++;
      if (pop !== e_pop || rx_pndng !== (rxq.size() != 0) || rx_data !== rx_head()) begin
        errs++;
        $display("FAIL rx_bp_fill[%0d] pop=%b rx=%h exp %b %h", i, pop, rx_data, e_pop, rx_head());
      end
    end
    checks++;
    if (pop !== 1'b0 || rxq.size() != D) begin
      errs++;
      $display("FAIL rx_bp_stall pop=%b model_occ=%0d exp 0 %0d", pop, rxq.size(), D);
    end
    rx_pop = 1;
    step();
    rx_pop = 0;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      data_out = pkt(1);
      step();
      if (pop === 1'b1 && first < 0) first = i;
      checks++;
      if (pop !== e_pop || rx_data !== rx_head()) begin
        errs++;
        $display("FAIL rx_bp_release[%0d] pop=%b rx=%h exp %b %h", i, pop, rx_data, e_pop, rx_head());
      end
    end
    checks++;
    if (first < 0 || first > 1) begin
      errs++;
      $display("FAIL rx_bp_latency got %0d exp 0..1", first);
    end
  endtask

  task automatic test_misroute();
    logic [PW-1:0] bad;
    bit seen;
    pndng = 0;
    rx_pop = 1;
    for (int i = 0; i < 8; i++) step();
    rx_pop = 0;
    bad = pkt(0);
    data_out = bad;
    pndng = 1;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      seen = pop === 1'b1;
    end
    pndng = 0;
    step();
    checks++;
    if (!seen || misroute !== 1'b1 || rx_data !== bad || rx_pndng !== 1'b1) begin
      errs++;
      $display("FAIL misroute_pulse seen=%b mis=%b rx=%h exp 1 1 %h", seen, misroute, rx_data, bad);
    end
    step();
    checks++;
    if (misroute !== 1'b0 || rx_data !== bad) begin
      errs++;
      $display("FAIL misroute_clear mis=%b rx=%h exp 0 %h", misroute, rx_data, bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tx_push = $urandom_range(0, 1) == 1;
      tx_data = {$urandom, 8'($urandom)};
      popin = $urandom_range(0, 1) == 1;
      pndng = $urandom_range(0, 3) != 0;
      data_out = pkt($urandom_range(0, 3) != 0);
      rx_pop = $urandom_range(0, 2) == 0;
      step();
      checks++;
      if (pop !== e_pop || misroute !== e_mis || rx_pndng !== (rxq.size() != 0) || rx_data !== rx_head() || rx_cnt !== CW'(m_rx_cnt)) begin
        errs++;
        $display("FAIL rand_rx[%0d] pop=%b mis=%b rx=%h cnt=%0d exp %b %b %h %0d", i, pop, misroute, rx_data, rx_cnt, e_pop, e_mis, rx_head(), m_rx_cnt);
      end
      checks++;
      if (tx_full !== (txq.size() == D) || pndng_i_in !== (txq.size() != 0) || data_out_i_in !== tx_head() || tx_cnt !== CW'(m_tx_cnt)) begin
        errs++;
        $display("FAIL rand_tx[%0d] full=%b pndng=%b dout=%h cnt=%0d exp %b %b %h %0d", i, tx_full, pndng_i_in, data_out_i_in, tx_cnt, txq.size() == D, txq.size() != 0, tx_head(), m_tx_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_drain();
    test_tx_full();
    test_rx_handshake();
    test_rx_backpressure();
    test_misroute();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
